// File: rtl/range_counter_pkg.sv
// Shared constants for the bounded up/down counter: direction and end-of-range
// mode encodings, plus the legacy 5..14 bounds.
package range_counter_pkg;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    localparam logic MODE_SAT  = 1'b0;
    localparam logic MODE_WRAP = 1'b1;

    localparam int unsigned LEGACY_LO = 5;
    localparam int unsigned LEGACY_HI = 14;

endpackage

// File: rtl/range_counter_next.sv
// Combinational next-state for the bounded counter. The range check is done before
// the increment/decrement, so in-range values never overflow.
module range_counter_next
    import range_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] val,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             dir,
    input  logic             wrap,
    output logic [WIDTH-1:0] next,
    output logic             at_bound,
    output logic             out_of_range
);

    always_comb begin
        next         = val;
        at_bound     = 1'b0;
        out_of_range = (val < lo) || (val > hi);

        if (out_of_range) begin
            // Recover to the bound we are heading towards; not a terminal count.
            next = (dir == DIR_UP) ? hi : lo;
        end else if (dir == DIR_DOWN) begin
            if (val > lo) begin
                next = val - WIDTH'(1);
            end else begin
                at_bound = 1'b1;
                next     = (wrap == MODE_WRAP) ? hi : lo;
            end
        end else begin
            if (val < hi) begin
                next = val + WIDTH'(1);
            end else begin
                at_bound = 1'b1;
                next     = (wrap == MODE_WRAP) ? lo : hi;
            end
        end
    end

endmodule

// File: rtl/range_counter.sv
// Bounded up/down counter with run-time range, direction and wrap/saturate choice,
// synchronous load, registered terminal-count pulse and config-error flag.
module range_counter
    import range_counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(LEGACY_HI)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             DIR,
    input  logic             WRAP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic [WIDTH-1:0] LO,
    input  logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] VAL,
    output logic             TC,
    output logic             ERR,
    output logic [WIDTH-1:0] LOG_LOGIC,
    output logic [WIDTH-1:0] LOG_SWITCHING
);

    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] val_d;
    logic             tc_q;
    logic             tc_d;
    logic             err_q;
    logic             cfg_err;
    logic [WIDTH-1:0] next_val;
    logic             at_bound;
    logic             out_of_range;

    range_counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .val          (val_q),
        .lo           (LO),
        .hi           (HI),
        .dir          (DIR),
        .wrap         (WRAP),
        .next         (next_val),
        .at_bound     (at_bound),
        .out_of_range (out_of_range)
    );

    assign cfg_err = (LO > HI);

    always_comb begin
        val_d = val_q;
        tc_d  = 1'b0;
        if (LOAD) begin
            val_d = LOAD_VAL;
        end else if (CE && !cfg_err) begin
            val_d = next_val;
            tc_d  = at_bound && !out_of_range;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            val_q <= RST_VAL;
            tc_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            val_q <= val_d;
            tc_q  <= tc_d;
            err_q <= cfg_err;
        end
    end

    assign VAL           = val_q;
    assign TC            = tc_q;
    assign ERR           = err_q;
    assign LOG_LOGIC     = next_val;
    assign LOG_SWITCHING = val_d;

endmodule

// File: tb/tb_range_counter.sv
// Bench for range_counter (WIDTH=4, RST_VAL=14): vector table with a queue of expected
// outputs, plus hand sequences for the debug taps and asynchronous reset.
module tb_range_counter;
    import range_counter_pkg::*;

    logic       CLK;
    logic       RST;
    logic       CE;
    logic       DIR;
    logic       WRAP;
    logic       LOAD;
    logic [3:0] LOAD_VAL;
    logic [3:0] LO;
    logic [3:0] HI;
    logic [3:0] VAL;
    logic       TC;
    logic       ERR;
    logic [3:0] LOG_LOGIC;
    logic [3:0] LOG_SWITCHING;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic       load;
        logic [3:0] load_val;
        logic       ce;
        logic       dir;
        logic       wrap;
        logic [3:0] lo;
        logic [3:0] hi;
        logic [3:0] exp_val;
        logic       exp_tc;
        logic       exp_err;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] val;
        logic       tc;
        logic       err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    range_counter #(
        .WIDTH   (4),
        .RST_VAL (4'd14)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .CE            (CE),
        .DIR           (DIR),
        .WRAP          (WRAP),
        .LOAD          (LOAD),
        .LOAD_VAL      (LOAD_VAL),
        .LO            (LO),
        .HI            (HI),
        .VAL           (VAL),
        .TC            (TC),
        .ERR           (ERR),
        .LOG_LOGIC     (LOG_LOGIC),
        .LOG_SWITCHING (LOG_SWITCHING)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input string n, input logic ld, input logic [3:0] lv,
                                input logic ce, input logic dir, input logic wrap,
                                input logic [3:0] lo, input logic [3:0] hi,
                                input logic [3:0] ev, input logic et, input logic ee);
        vec_t v;
        v.name = n; v.load = ld; v.load_val = lv; v.ce = ce; v.dir = dir; v.wrap = wrap;
        v.lo = lo; v.hi = hi; v.exp_val = ev; v.exp_tc = et; v.exp_err = ee;
        return v;
    endfunction

    task automatic cmp(input string n, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", n, act, exp);
        end
    endtask

    task automatic check_now(input string n, input logic [3:0] v, input logic t,
                             input logic e);
        cmp({n, ".val"}, VAL, v);
        cmp({n, ".tc"}, {3'b0, TC}, {3'b0, t});
        cmp({n, ".err"}, {3'b0, ERR}, {3'b0, e});
    endtask

    task automatic drive(input vec_t v);
        LOAD = v.load; LOAD_VAL = v.load_val; CE = v.ce; DIR = v.dir; WRAP = v.wrap;
        LO = v.lo; HI = v.hi;
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        drive(v);
        sb.push_back('{v.name, v.exp_val, v.exp_tc, v.exp_err});
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: got empty queue required entry");
        end else begin
            e = sb.pop_front();
            check_now(e.name, e.val, e.tc, e.err);
        end
    endtask

    initial begin
        vec_t v;

        // Legacy 14..5 wrapping down-counter.
        for (int i = 0; i < 9; i++)
            vecs.push_back(mk("legacy", 0, 0, 1, DIR_DOWN, MODE_WRAP, 5, 14, 4'(13 - i), 0, 0));
        vecs.push_back(mk("legacy_wrap", 0, 0, 1, DIR_DOWN, MODE_WRAP, 5, 14, 14, 1, 0));
        // Up-saturate 2..6.
        vecs.push_back(mk("sat_load", 1, 4, 1, DIR_UP, MODE_SAT, 2, 6, 4, 0, 0));
        vecs.push_back(mk("sat_5", 0, 0, 1, DIR_UP, MODE_SAT, 2, 6, 5, 0, 0));
        vecs.push_back(mk("sat_6", 0, 0, 1, DIR_UP, MODE_SAT, 2, 6, 6, 0, 0));
        vecs.push_back(mk("sat_hit1", 0, 0, 1, DIR_UP, MODE_SAT, 2, 6, 6, 1, 0));
        vecs.push_back(mk("sat_hit2", 0, 0, 1, DIR_UP, MODE_SAT, 2, 6, 6, 1, 0));
        // CE gating and load priority.
        vecs.push_back(mk("ce1_a", 0, 0, 1, DIR_DOWN, MODE_WRAP, 5, 14, 5, 0, 0));
        vecs.push_back(mk("ce0_a", 0, 0, 0, DIR_DOWN, MODE_WRAP, 5, 14, 5, 0, 0));
        vecs.push_back(mk("ce1_b", 0, 0, 1, DIR_DOWN, MODE_WRAP, 5, 14, 14, 1, 0));
        vecs.push_back(mk("ce0_b", 0, 0, 0, DIR_DOWN, MODE_WRAP, 5, 14, 14, 0, 0));
        vecs.push_back(mk("ce1_c", 0, 0, 1, DIR_DOWN, MODE_WRAP, 5, 14, 13, 0, 0));
        vecs.push_back(mk("load_ce", 1, 9, 1, DIR_DOWN, MODE_WRAP, 5, 14, 9, 0, 0));
        // Out-of-range recovery.
        vecs.push_back(mk("oor_ld15a", 1, 15, 0, DIR_DOWN, MODE_WRAP, 5, 14, 15, 0, 0));
        vecs.push_back(mk("oor_hi_dn", 0, 0, 1, DIR_DOWN, MODE_WRAP, 5, 14, 5, 0, 0));
        vecs.push_back(mk("oor_ld15b", 1, 15, 0, DIR_UP, MODE_WRAP, 5, 14, 15, 0, 0));
        vecs.push_back(mk("oor_hi_up", 0, 0, 1, DIR_UP, MODE_WRAP, 5, 14, 14, 0, 0));
        vecs.push_back(mk("oor_ld2a", 1, 2, 0, DIR_UP, MODE_WRAP, 5, 14, 2, 0, 0));
        vecs.push_back(mk("oor_lo_up", 0, 0, 1, DIR_UP, MODE_WRAP, 5, 14, 14, 0, 0));
        vecs.push_back(mk("oor_ld2b", 1, 2, 0, DIR_DOWN, MODE_WRAP, 5, 14, 2, 0, 0));
        vecs.push_back(mk("oor_lo_dn", 0, 0, 1, DIR_DOWN, MODE_WRAP, 5, 14, 5, 0, 0));
        // Config error: frozen, load still honoured, clears on valid bounds.
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk("cfg_err", 0, 0, 1, DIR_DOWN, MODE_WRAP, 10, 3, 5, 0, 1));
        vecs.push_back(mk("cfg_err_ld", 1, 7, 1, DIR_DOWN, MODE_WRAP, 10, 3, 7, 0, 1));
        vecs.push_back(mk("cfg_ok_a", 0, 0, 1, DIR_DOWN, MODE_WRAP, 3, 10, 6, 0, 0));
        vecs.push_back(mk("cfg_ok_b", 0, 0, 1, DIR_DOWN, MODE_WRAP, 3, 10, 5, 0, 0));
        // LO == HI pins the count.
        vecs.push_back(mk("pin_enter", 0, 0, 1, DIR_DOWN, MODE_WRAP, 8, 8, 8, 0, 0));
        vecs.push_back(mk("pin_tc1", 0, 0, 1, DIR_DOWN, MODE_WRAP, 8, 8, 8, 1, 0));
        vecs.push_back(mk("pin_tc2", 0, 0, 1, DIR_DOWN, MODE_WRAP, 8, 8, 8, 1, 0));
        vecs.push_back(mk("pin_tc_up", 0, 0, 1, DIR_UP, MODE_SAT, 8, 8, 8, 1, 0));
        // Full-width bounds 0..15.
        vecs.push_back(mk("full_ld15", 1, 15, 1, DIR_UP, MODE_WRAP, 0, 15, 15, 0, 0));
        vecs.push_back(mk("full_wrap_up", 0, 0, 1, DIR_UP, MODE_WRAP, 0, 15, 0, 1, 0));
        vecs.push_back(mk("full_wrap_dn", 0, 0, 1, DIR_DOWN, MODE_WRAP, 0, 15, 15, 1, 0));
        vecs.push_back(mk("full_ld0", 1, 0, 1, DIR_DOWN, MODE_SAT, 0, 15, 0, 0, 0));
        vecs.push_back(mk("full_sat0a", 0, 0, 1, DIR_DOWN, MODE_SAT, 0, 15, 0, 1, 0));
        vecs.push_back(mk("full_sat0b", 0, 0, 1, DIR_DOWN, MODE_SAT, 0, 15, 0, 1, 0));

        // Reset state, held without relying on a clock edge.
        RST = 1'b1;
        drive(mk("init", 0, 0, 1, DIR_DOWN, MODE_WRAP, 5, 14, 0, 0, 0));
        #2;
        check_now("reset", 14, 0, 0);
        @(negedge CLK);
        RST = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Debug taps: load mux, pre-enable next state, enable gating, config error hold.
        v = mk("tap_load", 1, 13, 0, DIR_DOWN, MODE_WRAP, 5, 14, 13, 0, 0);
        drive(v);
        #1;
        cmp("tap_sw_load", LOG_SWITCHING, 13);
        apply(v);
        LOAD = 1'b0;
        CE   = 1'b0;
        #1;
        cmp("tap_logic", LOG_LOGIC, 12);
        cmp("tap_sw_hold", LOG_SWITCHING, 13);
        CE = 1'b1;
        #1;
        cmp("tap_sw_ce", LOG_SWITCHING, 12);
        LO = 4'd10;
        HI = 4'd3;
        #1;
        cmp("tap_sw_err", LOG_SWITCHING, 13);

        // Async reset discards a pending TC without a clock edge.
        apply(mk("rst_ld5", 1, 5, 1, DIR_DOWN, MODE_WRAP, 5, 14, 5, 0, 0));
        apply(mk("rst_tc", 0, 0, 1, DIR_DOWN, MODE_WRAP, 5, 14, 14, 1, 0));
        #3;
        RST = 1'b1;
        #1;
        check_now("rst_async_tc", 14, 0, 0);
        @(negedge CLK);
        RST = 1'b0;
        apply(mk("rst_cnt13", 0, 0, 1, DIR_DOWN, MODE_WRAP, 5, 14, 13, 0, 0));
        apply(mk("rst_cnt12", 0, 0, 1, DIR_DOWN, MODE_WRAP, 5, 14, 12, 0, 0));
        #2;
        RST = 1'b1;
        #1;
        check_now("rst_async_val", 14, 0, 0);
        @(negedge CLK);
        RST = 1'b0;
        apply(mk("rst_restart", 0, 0, 1, DIR_DOWN, MODE_WRAP, 5, 14, 13, 0, 0));
        apply(mk("rst_err_set", 0, 0, 1, DIR_DOWN, MODE_WRAP, 10, 3, 13, 0, 1));
        #2;
        RST = 1'b1;
        #1;
        check_now("rst_async_err", 14, 0, 0);
        @(negedge CLK);
        RST = 1'b0;
        apply(mk("rst_err_after", 0, 0, 1, DIR_DOWN, MODE_WRAP, 5, 14, 13, 0, 0));

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/range_counter.md
Name: range_counter

Overview:
Parametrised bounded up/down counter with programmable inclusive range [LO, HI], a run-time direction, and a run-time choice between wrap and saturate. Supports synchronous load, a registered terminal-count pulse and a configuration-error flag. It generalises the fixed 4-bit 14-down-to-5 wrapping counter to any width, both directions and run-time bounds. It is a free-standing sequencer/timer stage for lab designs and keeps the same count-enable gating and next-state debug taps.

Parameters:
WIDTH, 4, counter and bound width in bits (2..16)
RST_VAL, 4'd14, VAL after reset; must be representable in WIDTH bits

Ports:
CLK  input  1  rising-edge clock
RST  input  1  asynchronous, active-high reset
CE  input  1  count enable; counter advances only when 1
DIR  input  1  0 = count down, 1 = count up
WRAP  input  1  1 = wrap at bound, 0 = saturate at bound
LOAD  input  1  synchronous load strobe
LOAD_VAL  input  WIDTH  value written on LOAD
LO  input  WIDTH  lower bound, inclusive
HI  input  WIDTH  upper bound, inclusive
VAL  output  WIDTH  registered count
TC  output  1  registered 1-cycle pulse on wrap or saturation hit
ERR  output  1  registered; 1 while LO > HI was sampled
LOG_LOGIC  output  WIDTH  combinational next-state (pre-enable)
LOG_SWITCHING  output  WIDTH  combinational D input of the VAL register (post-enable/load mux)

Behaviour:
- One clock (CLK), one asynchronous active-high reset (RST). While RST=1: VAL=RST_VAL, TC=0, ERR=0, regardless of the clock. Deassertion takes effect at the next CLK edge.
- All state updates occur on the CLK rising edge. VAL and the flags have 1-cycle latency from input sampling.
- Priority per edge: RST > LOAD > CE > hold.
- LOAD=1: VAL<=LOAD_VAL (any value, even out of range), TC<=0. CE is ignored that cycle.
- Config error (LO > HI): ERR<=1, VAL holds, TC<=0, LOAD still honoured. ERR clears on the first edge with LO <= HI.
- LOG_LOGIC (next-state) with LO <= HI:
  - out of range (VAL < LO or VAL > HI): DIR=0 -> LO, DIR=1 -> HI (recovery; no TC).
  - DIR=0, VAL > LO -> VAL-1.
  - DIR=0, VAL == LO -> HI if WRAP=1, else LO.
  - DIR=1, VAL < HI -> VAL+1.
  - DIR=1, VAL == HI -> LO if WRAP=1, else HI.
- LOG_SWITCHING = LOAD ? LOAD_VAL : (CE && !ERR_cond) ? LOG_LOGIC : VAL.
- TC<=1 for exactly one cycle on a CE edge where VAL is at the active bound (LO when down, HI when up), in range, with no LOAD. This covers both the wrap and the saturate case. While saturated with CE held, TC fires again on every CE edge.
- LO == HI: counter pins at that value and TC fires on every CE edge.
- Arithmetic is modulo 2^WIDTH internally, but range checks precede increment/decrement, so no overflow is reachable in range. Bounds at 0 or 2^WIDTH-1 are legal.
- DIR, WRAP, LO and HI may change on any cycle and are sampled at each edge; no extra state is kept.
- A mid-operation RST forces RST_VAL immediately and discards any pending TC.

Decomposition:
- Shared include file: the DIR_UP/DIR_DOWN and MODE_WRAP/MODE_SAT constants, plus the default bounds 5/14 for legacy configurations.
- Sub-module range_counter_next: pure combinational next-state (VAL, LO, HI, DIR, WRAP -> next, at_bound, out_of_range).
- Top level: the CE/LOAD switching mux and the existing D_FF-style register extended to WIDTH, with RST.

Test Plan:
- Legacy mode, WIDTH=4, LO=5, HI=14, DIR=0, WRAP=1, CE=1 after reset: VAL sequence 14,13,...,5,14. TC is high for one cycle coinciding with VAL going 5->14.
- Up-saturate, LO=2, HI=6, DIR=1, WRAP=0, LOAD_VAL=4: VAL 4,5,6,6,6. TC is high on each edge where VAL is already 6.
- CE gating and load priority: CE toggles 1,0,1 -> VAL advances only on CE=1 edges. With LOAD=1 and CE=1 together, LOAD_VAL=9 -> VAL=9 and TC=0.
- Out-of-range recovery: LOAD_VAL=15 with range 5..14, DIR=0 -> next CE edge gives VAL=5, with no TC. The same case with DIR=1 gives VAL=14.
- Config error: LO=10, HI=3 -> ERR=1 and VAL frozen across 3 CE edges. Restoring LO=3 -> ERR=0 on the next edge, and counting resumes.
- Async reset mid-count: assert RST between edges -> VAL=RST_VAL (14) and TC=0 immediately without a clock. After release, counting restarts from 14.
